// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg: FSM state encoding, Wishbone widths and the default error data word
package wb_cmd_master_pkg;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam logic [DAT_W-1:0] ERR_DATA_DEF = 32'hDEAD_DEAD;
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command to single Wishbone classic cycle, with ack timeout.
// Define WB_CMD_MASTER_ERR_EN to add the wbm_err_i bus-error input.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [DAT_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0] cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic [DAT_W-1:0] wbm_dat_i,
`ifdef WB_CMD_MASTER_ERR_EN
    input  logic             wbm_err_i,
`endif
    input  logic             wbm_ack_i,
    output logic             busy_o,
    output logic [7:0]       timeout_cnt_o
);
    state_t state, state_nx;
    logic err, tmo, done;
`ifdef WB_CMD_MASTER_ERR_EN
    assign err = wbm_err_i && state == BUS;
`else
    assign err = 1'b0;
`endif
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
            logic [TW-1:0] tcnt;
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) tcnt <= '0;
                else if (state == BUS) tcnt <= tcnt + TW'(1);
                else tcnt <= '0;
            end
            assign tmo = state == BUS && tcnt == TW'(TIMEOUT_CYCLES - 1);
        end else begin : g_no_tmo
            assign tmo = 1'b0;
        end
    endgenerate
    assign done = state == BUS && (wbm_ack_i || err || tmo);
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE && cmd_valid_i) ? BUS :
                   done ? RESP :
                   (state == RESP && rsp_ready_i) ? IDLE : state;
        cmd_ready_o = state == IDLE;
        busy_o = state != IDLE;
        wbm_cyc_o = state == BUS;
        wbm_stb_o = state == BUS;
        rsp_valid_o = state == RESP;
    end
    // Error priority on the ending edge: bus error, then ack, then timeout
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_we_o <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b0;
            timeout_cnt_o <= '0;
        end else if (state == IDLE && cmd_valid_i) begin
            wbm_we_o <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
        end else if (done) begin
            wbm_we_o <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_err_o <= err || !wbm_ack_i;
            rsp_dat_o <= err ? ERR_DATA : wbm_we_o ? {DAT_W{1'b0}} : wbm_ack_i ? wbm_dat_i : ERR_DATA;
            if (!err && !wbm_ack_i && timeout_cnt_o != 8'hFF) timeout_cnt_o <= timeout_cnt_o + 8'd1;
        end else if (state == RESP && rsp_ready_i) begin
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b0;
        end
    end
endmodule
